// File: rtl/cv32e40p_register_file_sb.sv
// Flip-flop register file with configurable read ports, optional FP bank,
// write-to-read bypass and a per-register busy scoreboard for port-B writebacks.
module cv32e40p_register_file_sb #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int FPU        = 0,
  parameter int ZFINX      = 0,
  parameter int NUM_RPORTS = 3,
  parameter int BYPASS     = 1
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0]                  raddr_i,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0]                  rdata_o,
  output logic [NUM_RPORTS-1:0]                             rbusy_o,
  input  logic [ADDR_WIDTH-1:0]                             waddr_a_i,
  input  logic [DATA_WIDTH-1:0]                             wdata_a_i,
  input  logic                                              we_a_i,
  input  logic [ADDR_WIDTH-1:0]                             waddr_b_i,
  input  logic [DATA_WIDTH-1:0]                             wdata_b_i,
  input  logic                                              we_b_i,
  input  logic                                              sb_set_i,
  input  logic [ADDR_WIDTH-1:0]                             sb_addr_i,
  input  logic                                              sb_flush_i,
  output logic [$clog2(((FPU == 1) && (ZFINX == 0)) ? 64 : 32):0] busy_cnt_o
);

  localparam bit HAS_FP        = (FPU == 1) && (ZFINX == 0);
  localparam int NUM_TOT_WORDS = HAS_FP ? 64 : 32;
  localparam int IDX_W         = $clog2(NUM_TOT_WORDS);
  localparam int CNT_W         = IDX_W + 1;

  // True for an address that maps to a real, writable register:
  // excludes integer x0 and the FP range when there is no FP bank.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (HAS_FP || !a[5]) && !(!a[5] && (a[4:0] == 5'd0));
  endfunction

  logic [DATA_WIDTH-1:0]    mem [NUM_TOT_WORDS];
  logic [NUM_TOT_WORDS-1:0] busy_q;
  logic [NUM_TOT_WORDS-1:0] busy_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;

  logic wa_ok;
  logic wb_ok;
  logic set_ok;
  logic [IDX_W-1:0] widx_a;
  logic [IDX_W-1:0] widx_b;
  logic [IDX_W-1:0] sidx;

  assign wa_ok  = we_a_i && addr_ok(waddr_a_i);
  assign wb_ok  = we_b_i && addr_ok(waddr_b_i);
  assign set_ok = sb_set_i && addr_ok(sb_addr_i);
  assign widx_a = waddr_a_i[IDX_W-1:0];
  assign widx_b = waddr_b_i[IDX_W-1:0];
  assign sidx   = sb_addr_i[IDX_W-1:0];

  // Port B is written last so it wins a same-address collision with port A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TOT_WORDS; i++) mem[i] <= '0;
    end else begin
      if (wa_ok) mem[widx_a] <= wdata_a_i;
      if (wb_ok) mem[widx_b] <= wdata_b_i;
    end
  end

  // A new issue overrides a same-cycle writeback; a flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (wb_ok)      busy_d[widx_b] = 1'b0;
    if (set_ok)     busy_d[sidx]   = 1'b1;
    if (sb_flush_i) busy_d         = '0;
    cnt_d = '0;
    for (int i = 0; i < NUM_TOT_WORDS; i++) cnt_d = cnt_d + CNT_W'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt_o = cnt_q;

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rb;

    assign ra = raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (addr_ok(ra)) begin
        rd = mem[ra[IDX_W-1:0]];
        rb = busy_q[ra[IDX_W-1:0]];
      end
      if (BYPASS != 0) begin
        if (wb_ok && (waddr_b_i == ra)) begin
          rd = wdata_b_i;
          rb = 1'b0;
        end else if (wa_ok && (waddr_a_i == ra)) begin
          rd = wdata_a_i;
        end
      end
    end

    assign rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy_o[p] = rb;
  end

endmodule

// File: tb/tb_cv32e40p_register_file_sb.sv
// Directed bench: two register files share stimulus, one with FP bank and
// bypass, one integer-only without bypass.
module tb_cv32e40p_register_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] raddr;
  logic [95:0] rdata_a, rdata_b;
  logic [2:0]  rbusy_a, rbusy_b;
  logic [5:0]  waddr_a, waddr_b, sb_addr;
  logic [31:0] wdata_a, wdata_b;
  logic        we_a, we_b, sb_set, sb_flush;
  logic [6:0]  cnt_a;
  logic [5:0]  cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cv32e40p_register_file_sb #(.FPU(1), .ZFINX(0), .NUM_RPORTS(3), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .sb_flush_i(sb_flush), .busy_cnt_o(cnt_a)
  );

  cv32e40p_register_file_sb #(.FPU(0), .ZFINX(0), .NUM_RPORTS(3), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .sb_flush_i(sb_flush), .busy_cnt_o(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 0; we_b = 0; sb_set = 0; sb_flush = 0;
    waddr_a = '0; waddr_b = '0; sb_addr = '0; wdata_a = '0; wdata_b = '0;
  endtask

  task automatic set_rd(input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2);
    raddr = {a2, a1, a0};
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    set_rd(6'd5, 6'd0, 6'h23);
    #3;
    check("rst_a_p0", rdata_a[31:0], 32'h0);
    check("rst_a_p1", rdata_a[63:32], 32'h0);
    check("rst_a_p2", rdata_a[95:64], 32'h0);
    check("rst_a_busy", {29'b0, rbusy_a}, 32'h0);
    check("rst_a_cnt", {25'b0, cnt_a}, 32'h0);
    check("rst_b_cnt", {26'b0, cnt_b}, 32'h0);
    #4 rst_n = 1'b1;
    step();

    // A and B collide on x7: B wins
    set_rd(6'd7, 6'd0, 6'd0);
    we_a = 1; waddr_a = 6'd7; wdata_a = 32'h11;
    we_b = 1; waddr_b = 6'd7; wdata_b = 32'h22;
    #1;
    check("byp_a_x7", rdata_a[31:0], 32'h22);
    check("nobyp_b_x7", rdata_b[31:0], 32'h0);
    step(); idle();
    check("x7_a", rdata_a[31:0], 32'h22);
    check("x7_b", rdata_b[31:0], 32'h22);

    // Different addresses both written
    we_a = 1; waddr_a = 6'd10; wdata_a = 32'hA;
    we_b = 1; waddr_b = 6'd11; wdata_b = 32'hB;
    step(); idle();
    set_rd(6'd10, 6'd11, 6'd0);
    #1;
    check("x10_b", rdata_b[31:0], 32'hA);
    check("x11_b", rdata_b[63:32], 32'hB);

    // Scoreboard set then writeback on x9
    set_rd(6'd9, 6'd0, 6'd0);
    sb_set = 1; sb_addr = 6'd9;
    step(); idle();
    check("x9_busy_a", {31'b0, rbusy_a[0]}, 32'h1);
    check("x9_busy_b", {31'b0, rbusy_b[0]}, 32'h1);
    check("cnt1_a", {25'b0, cnt_a}, 32'h1);
    we_b = 1; waddr_b = 6'd9; wdata_b = 32'hABCD;
    #1;
    check("x9_byp_data_a", rdata_a[31:0], 32'hABCD);
    check("x9_byp_busy_a", {31'b0, rbusy_a[0]}, 32'h0);
    check("x9_nobyp_busy_b", {31'b0, rbusy_b[0]}, 32'h1);
    step(); idle();
    check("cnt0_a", {25'b0, cnt_a}, 32'h0);
    check("cnt0_b", {26'b0, cnt_b}, 32'h0);
    check("x9_b", rdata_b[31:0], 32'hABCD);

    // Set and writeback on x4 together: stays busy
    set_rd(6'd4, 6'd6, 6'd0);
    sb_set = 1; sb_addr = 6'd4; we_b = 1; waddr_b = 6'd4; wdata_b = 32'h5;
    step(); idle();
    check("x4_data", rdata_b[31:0], 32'h5);
    check("x4_busy", {31'b0, rbusy_b[0]}, 32'h1);
    check("x4_cnt", {26'b0, cnt_b}, 32'h1);
    // Port-A write to a busy register keeps it busy
    we_a = 1; waddr_a = 6'd4; wdata_a = 32'h44;
    step(); idle();
    check("x4_a_data", rdata_b[31:0], 32'h44);
    check("x4_a_busy", {31'b0, rbusy_a[0]}, 32'h1);
    sb_set = 1; sb_addr = 6'd6; sb_flush = 1;
    step(); idle();
    check("flush_cnt_a", {25'b0, cnt_a}, 32'h0);
    check("flush_busy_a", {29'b0, rbusy_a}, 32'h0);
    check("flush_busy_b", {29'b0, rbusy_b}, 32'h0);

    // x0 is immune to writes and scoreboard sets
    set_rd(6'd0, 6'd0, 6'd0);
    we_a = 1; waddr_a = 6'd0; wdata_a = 32'hFFFF;
    we_b = 1; waddr_b = 6'd0; wdata_b = 32'hFFFF;
    sb_set = 1; sb_addr = 6'd0;
    #1;
    check("x0_byp_a", rdata_a[31:0], 32'h0);
    step(); idle();
    check("x0_a", rdata_a[31:0], 32'h0);
    check("x0_busy_a", {31'b0, rbusy_a[0]}, 32'h0);
    check("x0_cnt_a", {25'b0, cnt_a}, 32'h0);

    // 0x23: f3 on the FP bank, out of range without it
    set_rd(6'd0, 6'd0, 6'h23);
    we_a = 1; waddr_a = 6'h23; wdata_a = 32'h77; sb_set = 1; sb_addr = 6'h23;
    step(); idle();
    check("f3_a", rdata_a[95:64], 32'h77);
    check("f3_busy_a", {31'b0, rbusy_a[2]}, 32'h1);
    check("f3_cnt_a", {25'b0, cnt_a}, 32'h1);
    check("oor_b", rdata_b[95:64], 32'h0);
    check("oor_busy_b", {31'b0, rbusy_b[2]}, 32'h0);
    check("oor_cnt_b", {26'b0, cnt_b}, 32'h0);
    sb_flush = 1;
    step(); idle();
    check("flush2_cnt_a", {25'b0, cnt_a}, 32'h0);

    // Fill x1..x31
    for (int i = 1; i < 32; i++) begin
      sb_set = 1; sb_addr = 6'(i);
      step();
    end
    idle();
    set_rd(6'd7, 6'd31, 6'd0);
    #1;
    check("full_cnt_a", {25'b0, cnt_a}, 32'd31);
    check("full_cnt_b", {26'b0, cnt_b}, 32'd31);
    check("full_x31_busy", {31'b0, rbusy_b[1]}, 32'h1);
    check("pre_rst_x7", rdata_b[31:0], 32'h22);

    // Asynchronous reset in the middle of a cycle
    #1 rst_n = 1'b0;
    #1;
    check("arst_x7_a", rdata_a[31:0], 32'h0);
    check("arst_x7_b", rdata_b[31:0], 32'h0);
    check("arst_busy_b", {29'b0, rbusy_b}, 32'h0);
    check("arst_cnt_a", {25'b0, cnt_a}, 32'h0);
    check("arst_cnt_b", {26'b0, cnt_b}, 32'h0);
    #3 rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
